// File: rtl/tpu_compute_ctrl.sv
// TPU front end: registered instruction decode, row-input skew, and two column accumulator banks.
// TPU_ACC_ADD_EN makes captures add into the banks. Decode has one cycle of latency; a_in is combinational; no backpressure.
module tpu_compute_ctrl #(
  parameter int ACC1_START = 2,
  parameter int ACC2_START = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [31:0] a11,
  input  logic [31:0] a12,
  input  logic [31:0] a21,
  input  logic [31:0] a22,
  input  logic [31:0] col1_in,
  input  logic [31:0] col2_in,
  output logic [12:0] base_address,
  output logic        load_weight,
  output logic        load_input,
  output logic        valid,
  output logic        store,
  output logic [15:0] a_in1,
  output logic [15:0] a_in2,
  output logic [31:0] acc1_mem_0,
  output logic [31:0] acc1_mem_1,
  output logic [31:0] acc2_mem_0,
  output logic [31:0] acc2_mem_1,
  output logic        acc1_full,
  output logic        acc2_full
);

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_LOAD_ADDR   = 3'b001,
    OP_LOAD_WEIGHT = 3'b010,
    OP_LOAD_INPUT  = 3'b011,
    OP_COMPUTE     = 3'b100,
    OP_STORE       = 3'b101,
    OP_RSVD6       = 3'b110,
    OP_RSVD7       = 3'b111
  } opcode_t;

  localparam logic [2:0] ACC1_S0 = 3'(ACC1_START);
  localparam logic [2:0] ACC1_S1 = 3'(ACC1_START + 1);
  localparam logic [2:0] ACC2_S0 = 3'(ACC2_START);
  localparam logic [2:0] ACC2_S1 = 3'(ACC2_START + 1);

  opcode_t    op;
  logic [2:0] s;
  logic       unused_hi;

  assign op = opcode_t'(instruction[15:13]);

  // Only the low half of each activation word feeds the array.
  assign unused_hi = ^{a11[31:16], a12[31:16], a21[31:16], a22[31:16]};

  function automatic logic [31:0] capture(input logic [31:0] old, input logic [31:0] col);
`ifdef TPU_ACC_ADD_EN
    return old + col;
`else
    return col;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_address <= '0;
      load_weight  <= 1'b0;
      load_input   <= 1'b0;
      valid        <= 1'b0;
      store        <= 1'b0;
    end else begin
      load_weight <= (op == OP_LOAD_WEIGHT);
      load_input  <= (op == OP_LOAD_INPUT);
      valid       <= (op == OP_COMPUTE);
      store       <= (op == OP_STORE);
      if (op == OP_LOAD_ADDR) base_address <= instruction[12:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= '0;
    end else if (valid) begin
      if (s != 3'd7) s <= s + 3'd1;
    end else begin
      s <= '0;
    end
  end

  always_comb begin
    a_in1 = '0;
    a_in2 = '0;
    if (valid) begin
      case (s)
        3'd0: a_in1 = a11[15:0];
        3'd1: begin
          a_in1 = a12[15:0];
          a_in2 = a21[15:0];
        end
        3'd2: a_in2 = a22[15:0];
        default: ;
      endcase
    end
  end

  // A new compute pass (s==0) clears full; the mem_1 write sets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc1_mem_0 <= '0;
      acc1_mem_1 <= '0;
      acc1_full  <= 1'b0;
    end else if (valid) begin
      if (s == ACC1_S0) acc1_mem_0 <= capture(acc1_mem_0, col1_in);
      if (s == ACC1_S1) begin
        acc1_mem_1 <= capture(acc1_mem_1, col1_in);
        acc1_full  <= 1'b1;
      end else if (s == 3'd0) begin
        acc1_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc2_mem_0 <= '0;
      acc2_mem_1 <= '0;
      acc2_full  <= 1'b0;
    end else if (valid) begin
      if (s == ACC2_S0) acc2_mem_0 <= capture(acc2_mem_0, col2_in);
      if (s == ACC2_S1) begin
        acc2_mem_1 <= capture(acc2_mem_1, col2_in);
        acc2_full  <= 1'b1;
      end else if (s == 3'd0) begin
        acc2_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_compute_ctrl.sv
// Scoreboard bench for tpu_compute_ctrl: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_tpu_compute_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [31:0] a11, a12, a21, a22, col1_in, col2_in;
  logic [12:0] base_address;
  logic        load_weight, load_input, valid, store;
  logic [15:0] a_in1, a_in2;
  logic [31:0] acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
  logic        acc1_full, acc2_full;

  int checks = 0;
  int failures = 0;

  tpu_compute_ctrl #(.ACC1_START(2), .ACC2_START(3)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .col1_in(col1_in), .col2_in(col2_in),
    .base_address(base_address), .load_weight(load_weight), .load_input(load_input),
    .valid(valid), .store(store), .a_in1(a_in1), .a_in2(a_in2),
    .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
    .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
    .acc1_full(acc1_full), .acc2_full(acc2_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] base;
    logic        lw, li, v, st;
    logic [15:0] ai1, ai2;
    logic [31:0] m10, m11, m20, m21;
    logic        f1, f2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: idx counts cycles since the current compute pass began.
  int          idx;
  logic        mv, mlw, mli, mst, f1, f2;
  logic [12:0] mbase;
  logic [31:0] m1 [2];
  logic [31:0] m2 [2];

  function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] c);
`ifdef TPU_ACC_ADD_EN
    return old + c;
`else
    return c;
`endif
  endfunction

  task automatic model_clear();
    idx = 0; mv = 0; mlw = 0; mli = 0; mst = 0; f1 = 0; f2 = 0; mbase = '0;
    m1[0] = '0; m1[1] = '0; m2[0] = '0; m2[1] = '0;
  endtask

  task automatic model_edge();
    logic [2:0] op;
    if (mv) begin
      if (idx == 0) begin f1 = 0; f2 = 0; end
      if (idx == 2) m1[0] = upd(m1[0], col1_in);
      if (idx == 3) begin m1[1] = upd(m1[1], col1_in); f1 = 1; end
      if (idx == 3) m2[0] = upd(m2[0], col2_in);
      if (idx == 4) begin m2[1] = upd(m2[1], col2_in); f2 = 1; end
      idx = idx + 1;
    end else begin
      idx = 0;
    end
    op = instruction[15:13];
    if (op == 3'd1) mbase = instruction[12:0];
    mlw = (op == 3'd2);
    mli = (op == 3'd3);
    mv  = (op == 3'd4);
    mst = (op == 3'd5);
  endtask

  task automatic push_expected();
    exp_t e;
    e.base = mbase; e.lw = mlw; e.li = mli; e.v = mv; e.st = mst;
    e.ai1 = (mv && idx == 0) ? a11[15:0] : (mv && idx == 1) ? a12[15:0] : 16'd0;
    e.ai2 = (mv && idx == 1) ? a21[15:0] : (mv && idx == 2) ? a22[15:0] : 16'd0;
    e.m10 = m1[0]; e.m11 = m1[1]; e.m20 = m2[0]; e.m21 = m2[1];
    e.f1 = f1; e.f2 = f2;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("base_address", 32'(base_address), 32'(e.base));
      chk("load_weight", 32'(load_weight), 32'(e.lw));
      chk("load_input", 32'(load_input), 32'(e.li));
      chk("valid", 32'(valid), 32'(e.v));
      chk("store", 32'(store), 32'(e.st));
      chk("a_in1", 32'(a_in1), 32'(e.ai1));
      chk("a_in2", 32'(a_in2), 32'(e.ai2));
      chk("acc1_mem_0", acc1_mem_0, e.m10);
      chk("acc1_mem_1", acc1_mem_1, e.m11);
      chk("acc2_mem_0", acc2_mem_0, e.m20);
      chk("acc2_mem_1", acc2_mem_1, e.m21);
      chk("acc1_full", 32'(acc1_full), 32'(e.f1));
      chk("acc2_full", 32'(acc2_full), 32'(e.f2));
    end
  end

  // Inputs change at posedge+1; the model applies the edge that just happened first.
  task automatic cycle(input logic [15:0] ins, input logic [31:0] c1, input logic [31:0] c2,
                       input bit do_rst, input bit rel_rst, input bit skew_a);
    @(posedge clk);
    #1;
    if (reset) model_edge();
    if (do_rst) begin reset = 1'b0; model_clear(); end
    if (rel_rst) reset = 1'b1;
    instruction = ins; col1_in = c1; col2_in = c2;
    if (skew_a) begin
      a11 = 32'd1; a12 = 32'd2; a21 = 32'd3; a22 = 32'd4;
    end else begin
      a11 = $urandom; a12 = $urandom; a21 = $urandom; a22 = $urandom;
    end
    push_expected();
  endtask

  task automatic step(input logic [15:0] ins);
    cycle(ins, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(16'h0000, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    cycle(16'h0000, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic capture_run();
    for (int k = 0; k < 7; k++)
      cycle((k < 6) ? 16'h8000 : 16'h0000,
            (k == 3) ? 32'd10 : (k == 4) ? 32'd20 : $urandom,
            (k == 4) ? 32'd30 : (k == 5) ? 32'd40 : $urandom,
            1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; instruction = '0; col1_in = '0; col2_in = '0;
    a11 = '0; a12 = '0; a21 = '0; a22 = '0;
    model_clear();
    cycle(16'h0000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle(16'h0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(16'h0000);

    step(16'h200F); step(16'h0000); step(16'h201E); step(16'h0000);
    step(16'h4000); step(16'h6000); step(16'hA000); step(16'hE000); step(16'h0000);

    for (int k = 0; k < 7; k++)
      cycle((k < 6) ? 16'h8000 : 16'h0000, $urandom, $urandom, 1'b0, 1'b0, 1'b1);

    do_reset();
    capture_run();
    @(negedge clk);
    chk("run1_acc1_mem_0", acc1_mem_0, 32'd10);
    chk("run1_acc1_mem_1", acc1_mem_1, 32'd20);
    chk("run1_acc2_mem_0", acc2_mem_0, 32'd30);
    chk("run1_acc2_mem_1", acc2_mem_1, 32'd40);
    chk("run1_full", 32'({acc1_full, acc2_full}), 32'd3);
    capture_run();
    @(negedge clk);
`ifdef TPU_ACC_ADD_EN
    chk("run2_acc1_mem_0", acc1_mem_0, 32'd20);
    chk("run2_acc1_mem_1", acc1_mem_1, 32'd40);
    chk("run2_acc2_mem_0", acc2_mem_0, 32'd60);
    chk("run2_acc2_mem_1", acc2_mem_1, 32'd80);
`else
    chk("run2_acc1_mem_0", acc1_mem_0, 32'd10);
    chk("run2_acc1_mem_1", acc1_mem_1, 32'd20);
    chk("run2_acc2_mem_0", acc2_mem_0, 32'd30);
    chk("run2_acc2_mem_1", acc2_mem_1, 32'd40);
`endif

    // Reset in the middle of a compute pass, then release with NOP.
    step(16'h8000); step(16'h8000); step(16'h8000); step(16'h8000);
    cycle(16'h8000, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    cycle(16'h0000, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    step(16'h0000);

    for (int i = 0; i < 300; i++) begin
      int r;
      int len;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 40) begin
        len = $urandom_range(1, 9);
        for (int k = 0; k < len; k++) step({3'b100, 13'($urandom)});
      end else begin
        step({3'($urandom), 13'($urandom)});
      end
    end

    step(16'h0000);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_compute_ctrl.md
Name: tpu_compute_ctrl

Overview:
- Front-end sequencing block of the 2x2 TPU datapath; combines three functions.
- Control unit: decodes 16-bit instructions into load/compute/store strobes and a 13-bit base address.
- Input setup: skews four unified-buffer activations into the two systolic row inputs.
- Accumulators: two column accumulators capture systolic column outputs into 2-entry banks and flag when full for unified-buffer write-back.

Parameters:
ACC1_START, 2, valid-cycle index of first capture for column 1
ACC2_START, 3, valid-cycle index of first capture for column 2 (one cycle later due to array skew)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
instruction  in  16  [15:13] opcode, [12:0] operand
a11, a12, a21, a22  in  32 each  activations from unified buffer; low 16 bits used
col1_in  in  32  systolic column-1 partial-sum output
col2_in  in  32  systolic column-2 partial-sum output
base_address  out  13  latched address
load_weight  out  1  weight-load strobe
load_input  out  1  input-load strobe
valid  out  1  compute-active
store  out  1  store strobe
a_in1  out  16  systolic row-1 activation
a_in2  out  16  systolic row-2 activation
acc1_mem_0, acc1_mem_1  out  32 each  column-1 bank
acc2_mem_0, acc2_mem_1  out  32 each  column-2 bank
acc1_full, acc2_full  out  1 each  bank fully written

Behaviour:
- Reset (reset=0, async): all outputs 0; step counter s=0; all banks 0.
- Decode is registered: instruction sampled at edge t; strobes reflect it from t+1.
- Opcodes:
  - 000 NOP: all strobes 0.
  - 001 LOAD_ADDR: base_address <= operand; strobes 0.
  - 010 LOAD_WEIGHT: load_weight=1.
  - 011 LOAD_INPUT: load_input=1.
  - 100 COMPUTE: valid=1.
  - 101 STORE: store=1.
  - 110/111: treated as NOP.
- At most one strobe high per cycle.
- base_address changes only on LOAD_ADDR and otherwise holds.
- A held COMPUTE instruction keeps valid high for consecutive cycles.
- Step counter s:
  - Each edge with valid=1: s <= s+1, saturating at 7.
  - Each edge with valid=0: s <= 0.
- a_in outputs are combinational from valid and s:
  - valid=0: (a_in1, a_in2) = (0, 0).
  - valid=1, s=0: (a11, 0).
  - s=1: (a12, a21).
  - s=2: (0, a22).
  - s>=3: (0, 0).
- Accumulator k captures colk_in on an edge with valid=1:
  - s == ACCk_START writes mem_0.
  - s == ACCk_START+1 writes mem_1.
- accK_full:
  - Registered; set on the edge that writes mem_1.
  - Held while valid=1.
  - Cleared on the first valid edge with s=0 (new compute) or by reset.
- Bank contents hold after valid drops; they are read by unified buffer on full.
- valid dropping mid-sequence: s clears, unwritten entries keep old values, full stays as-is until the next compute start.
- Nominal COMPUTE length is 6 cycles (s 0..5), which covers both banks.
- All arithmetic is unsigned 32-bit; wrap-around on overflow, no flags.

Optional Feature:
- Macro TPU_ACC_ADD_EN.
- Defined: each capture adds into the existing entry (mem <= mem + colk_in, 32-bit wrap), accumulating across COMPUTE passes; banks clear only on reset.
- Undefined: capture overwrites the entry.

Test Plan:
- Reset: drive reset=0 mid-run -> all outputs 0 immediately; release -> outputs remain 0 with NOP.
- Address decode: LOAD_ADDR 0x000F -> base_address=15 next cycle; then NOP -> stays 15; LOAD_ADDR 0x001E -> 30.
- Strobes: LOAD_WEIGHT, LOAD_INPUT, STORE, opcode 111 -> load_weight, load_input, store each high exactly one cycle; opcode 111 gives no strobe.
- Skew: a11=1, a12=2, a21=3, a22=4, COMPUTE for 6 cycles -> (a_in1, a_in2) = (1,0), (2,3), (0,4), (0,0), (0,0), (0,0).
- Capture: col1_in=10,20 at s=2,3 and col2_in=30,40 at s=3,4 -> acc1_mem = {10,20}, acc2_mem = {30,40}; acc1_full rises after s=3, acc2_full after s=4; both clear at the next COMPUTE start.
- With TPU_ACC_ADD_EN: repeat the capture scenario twice -> acc1_mem={20,40}, acc2_mem={60,80}; without the macro -> {10,20}, {30,40}.
